// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer for the RV32I core.
// Accepts one decoded load/store at a time, forms ea = rs1 + imm, screens
// funct3 and alignment, runs a valid/ready data-memory request and, for
// loads, aligns/extends the returned word into a register writeback.
// Exceptions (misaligned, illegal funct3, bus timeout) leave as a one-cycle
// pulse carrying the cause and faulting effective address.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_*                         request in (valid/ready, is_store, funct3,
//                                 rs1, imm, rs2, rd)
//   mem_req_* / mem_addr/we/be/wdata   memory request (valid/ready)
//   mem_rsp_valid, mem_rdata      load response
//   wb_valid, wb_rd, wb_data      register writeback strobe
//   done                          successful completion pulse
//   exc_valid, exc_cause, exc_addr  exception pulse
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1_val,
    input  logic [31:0] req_imm,
    input  logic [31:0] req_rs2_val,
    input  logic [4:0]  req_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_EXC} state_t;

    typedef struct packed {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] ea;
        logic [4:0]  rd;
    } req_t;

    state_t      state, state_d;
    req_t        req_q, req_d;
    logic [7:0]  cnt, cnt_d;

    logic        mem_req_valid_d, mem_we_d, wb_valid_d, done_d, exc_valid_d;
    logic [31:0] mem_addr_d, mem_wdata_d, wb_data_d, exc_addr_d;
    logic [3:0]  mem_be_d;
    logic [4:0]  wb_rd_d;
    logic [1:0]  exc_cause_d;

    // Incoming request decode (only meaningful while IDLE)
    logic [31:0] ea_in, wdata_in;
    logic        legal_in, misal_in;
    logic [3:0]  be_in;

    assign ea_in = req_rs1_val + req_imm;

    always_comb begin
        legal_in = 1'b0;
        misal_in = 1'b0;
        be_in    = 4'b1111;
        wdata_in = req_rs2_val;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal_in = 1'b1;
            3'b100, 3'b101:         legal_in = !req_is_store;
            default:                legal_in = 1'b0;
        endcase
        // funct3[1:0] is the access size: 00 byte, 01 half, 10 word
        case (req_funct3[1:0])
            2'b00: begin
                be_in    = 4'b0001 << ea_in[1:0];
                wdata_in = {4{req_rs2_val[7:0]}};
            end
            2'b01: begin
                be_in    = 4'b0011 << ea_in[1:0];
                wdata_in = {2{req_rs2_val[15:0]}};
                misal_in = ea_in[0];
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = req_rs2_val;
                misal_in = (ea_in[1:0] != 2'b00);
            end
        endcase
    end

    // Load data alignment and extension, driven from the held request
    logic [31:0] rshift, ld_data;

    assign rshift = mem_rdata >> {req_q.ea[1:0], 3'b000};

    always_comb begin
        ld_data = rshift;
        case (req_q.funct3)
            3'b000:  ld_data = {{24{rshift[7]}}, rshift[7:0]};
            3'b100:  ld_data = {24'h0, rshift[7:0]};
            3'b001:  ld_data = {{16{rshift[15]}}, rshift[15:0]};
            3'b101:  ld_data = {16'h0, rshift[15:0]};
            default: ld_data = rshift;
        endcase
    end

    assign req_ready = (state == S_IDLE);

    // Next state plus next values of every registered output. Pulses default
    // low; request/writeback/exception payloads hold unless updated.
    always_comb begin
        state_d         = state;
        req_d           = req_q;
        cnt_d           = cnt;
        mem_req_valid_d = mem_req_valid;
        mem_addr_d      = mem_addr;
        mem_we_d        = mem_we;
        mem_be_d        = mem_be;
        mem_wdata_d     = mem_wdata;
        wb_valid_d      = 1'b0;
        wb_rd_d         = wb_rd;
        wb_data_d       = wb_data;
        done_d          = 1'b0;
        exc_valid_d     = 1'b0;
        exc_cause_d     = exc_cause;
        exc_addr_d      = exc_addr;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    req_d = '{is_store: req_is_store, funct3: req_funct3,
                              ea: ea_in, rd: req_rd};
                    if (!legal_in || misal_in) begin
                        // illegal funct3 outranks misalignment
                        exc_valid_d = 1'b1;
                        exc_cause_d = !legal_in ? 2'd2 : (req_is_store ? 2'd1 : 2'd0);
                        exc_addr_d  = ea_in;
                        state_d     = S_EXC;
                    end else begin
                        mem_req_valid_d = 1'b1;
                        mem_addr_d      = {ea_in[31:2], 2'b00};
                        mem_we_d        = req_is_store;
                        mem_be_d        = be_in;
                        mem_wdata_d     = wdata_in;
                        state_d         = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    if (req_q.is_store) begin
                        done_d  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    done_d     = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = req_q.rd;
                    wb_data_d  = ld_data;
                    state_d    = S_RESP;
                end else if (cnt == CNT_LAST) begin
                    exc_valid_d = 1'b1;
                    exc_cause_d = 2'd3;
                    exc_addr_d  = req_q.ea;
                    state_d     = S_EXC;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            req_q         <= '0;
            cnt           <= 8'd0;
            mem_req_valid <= 1'b0;
            mem_addr      <= 32'h0;
            mem_we        <= 1'b0;
            mem_be        <= 4'h0;
            mem_wdata     <= 32'h0;
            wb_valid      <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= 32'h0;
            done          <= 1'b0;
            exc_valid     <= 1'b0;
            exc_cause     <= 2'd0;
            exc_addr      <= 32'h0;
        end else begin
            state         <= state_d;
            req_q         <= req_d;
            cnt           <= cnt_d;
            mem_req_valid <= mem_req_valid_d;
            mem_addr      <= mem_addr_d;
            mem_we        <= mem_we_d;
            mem_be        <= mem_be_d;
            mem_wdata     <= mem_wdata_d;
            wb_valid      <= wb_valid_d;
            wb_rd         <= wb_rd_d;
            wb_data       <= wb_data_d;
            done          <= done_d;
            exc_valid     <= exc_valid_d;
            exc_cause     <= exc_cause_d;
            exc_addr      <= exc_addr_d;
        end
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencing controller for the RV32I core. It takes one decoded load/store at a time, with rs1, the sign-extended immediate from the immediate generator, and rs2. It computes the effective address, checks alignment and funct3, and drives a valid/ready data-memory port. For loads it aligns and extends the returned data and issues a register-file writeback. It raises a one-cycle exception pulse for illegal funct3, misaligned access, or bus timeout.

Parameters:
TIMEOUT_CYCLES, 16, number of WAIT cycles without mem_rsp_valid before a bus-timeout exception (legal range 2..255).

Ports:
clk  in  1  clock, all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_is_store  in  1  1 = store, 0 = load
req_funct3  in  3  instruction[14:12]
req_rs1_val  in  32  base register value
req_imm  in  32  sign-extended immediate
req_rs2_val  in  32  store data
req_rd  in  5  load destination register
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  32  word-aligned address, {ea[31:2],2'b00}
mem_we  out  1  1 = write
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rsp_valid  in  1  load data valid
mem_rdata  in  32  load data word
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  writeback register
wb_data  out  32  extended load result
done  out  1  one-cycle completion pulse for any successful op
exc_valid  out  1  one-cycle exception pulse
exc_cause  out  2  0 load-misaligned, 1 store-misaligned, 2 illegal funct3, 3 bus timeout
exc_addr  out  32  faulting effective address

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE.
  - All registered outputs are 0: mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata, wb_valid, wb_rd, wb_data, done, exc_valid, exc_cause, exc_addr. The timeout counter is 0.
  - req_ready = (state==IDLE), so it reads 1 during and after reset.
- Reset mid-operation aborts immediately: mem_req_valid drops, and any later mem_rsp_valid is ignored.
- Effective address: ea = req_rs1_val + req_imm, modulo 2^32. Carry is discarded; 0xFFFFFFFC + 8 = 0x00000004.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other values are illegal.
- Misalignment: half access with ea[0]=1; word access with ea[1:0]!=0. Byte access is never misaligned.
- Exception precedence: illegal funct3 over misaligned.
- States:
  - IDLE: req_ready=1. On req_valid, register the request fields and ea. A faulting request goes to EXC; otherwise go to ISSUE.
  - ISSUE: mem_req_valid=1. mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_req_ready. On the handshake, a store goes to RESP and a load goes to WAIT with the counter cleared.
  - WAIT: mem_rsp_valid is sampled only in this state, so a response arrives at the earliest one cycle after the request handshake. On rsp, capture the extended data and go to RESP. Otherwise increment the counter; when the counter reaches TIMEOUT_CYCLES-1 without rsp, go to EXC with cause 3.
  - RESP (one cycle): done=1. wb_valid=1 for loads only, with wb_rd and wb_data valid. Then go to IDLE.
  - EXC (one cycle): exc_valid=1 with exc_cause and exc_addr=ea. No memory request is issued for cause 0–2. Then go to IDLE.
- Byte enables (o = ea[1:0]): byte 4'b0001<<o; half 4'b0011<<o; word 4'b1111.
- Store data: SB {4{rs2[7:0]}}; SH {2{rs2[15:0]}}; SW rs2.
- Load data: r = mem_rdata >> (8*o).
  - LB sign-extends r[7:0]; LBU zero-extends r[7:0].
  - LH sign-extends r[15:0]; LHU zero-extends r[15:0].
  - LW returns r.
- Latency, with mem_req_ready tied high:
  - Store accepted at cycle T gives done at T+2.
  - Load with rsp in the first WAIT cycle gives wb_valid at T+3.
- req_ready=0 in every state except IDLE, so at most one operation is in flight.

Test Plan:
- SW rs1=0x1000 imm=4 rs2=0xDEADBEEF, ready=1 -> mem_addr=0x1004, be=1111, we=1, wdata=0xDEADBEEF; done 2 cycles after accept; wb_valid stays 0.
- LB rs1=0x2000 imm=3, rdata=0x80FF7F01 -> be=1000, wb_data=0xFFFFFF80; LBU with the same stimulus -> 0x00000080; LHU ea=0x2002 -> 0x000080FF.
- SH ea=0x3001 -> exc_valid pulse, cause=1, exc_addr=0x3001, mem_req_valid never asserted; funct3=011 load -> cause=2 (illegal beats misaligned).
- LW with mem_req_ready low for 5 cycles -> address/be held stable; handshake on cycle 6; a response arriving on the handshake cycle itself is not taken.
- LW with no rsp, TIMEOUT_CYCLES=16 -> exc cause=3 after 16 WAIT cycles, then req_ready=1.
- rst_n pulsed low during WAIT -> all outputs 0 immediately; late mem_rsp_valid produces no wb_valid; next request completes normally.
